// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, legal parameter ranges
// and a parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int DATA_BITS_MIN  = 5;
    localparam int DATA_BITS_MAX  = 8;
    localparam int STOP_BITS_MIN  = 1;
    localparam int STOP_BITS_MAX  = 2;
    localparam int OVERSAMPLE_MIN = 4;

    // Even-parity reduction of a data byte (unused upper bits must be zero).
    function automatic logic parity_of(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a
// configurable reset value so idle-high and idle-low lines both fit.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next values of the two synchronizer stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: mid-bit sampling, LSB-first data, optional
// parity, 1-2 stop bits, valid/ready output register with error flags.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_tick,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] SAMP_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] SAMP_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
        $error("uart_rx_os: DATA_BITS must be 5..8");
    end
    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
        $error("uart_rx_os: STOP_BITS must be 1 or 2");
    end
    if (OVERSAMPLE < OVERSAMPLE_MIN || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
        $error("uart_rx_os: OVERSAMPLE must be even and at least 4");
    end

    logic rx_s;
    logic load_s;

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] samp_q, samp_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             valid_q, valid_d;
    logic             pe_q, pe_d;
    logic             fe_q, fe_d;
    logic             ovr_q, ovr_d;
    logic             busy_q, busy_d;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // Frame FSM: advances only on baud_tick; after the start check the
    // counter is re-zeroed so every later wrap lands mid-bit.
    always_comb begin
        state_d = state_q;
        samp_d  = samp_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        load_s  = 1'b0;
        if (baud_tick) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        samp_d  = {CNT_W{1'b0}};
                        bit_d   = 3'd0;
                        shift_d = 8'h00;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
                START: begin
                    if (samp_q == SAMP_HALF) begin
                        samp_d  = {CNT_W{1'b0}};
                        state_d = rx_s ? IDLE : DATA;
                    end else begin
                        samp_d = samp_q + 1'b1;
                    end
                end
                DATA: begin
                    if (samp_q == SAMP_LAST) begin
                        samp_d         = {CNT_W{1'b0}};
                        shift_d[bit_q] = rx_s;
                        if (bit_q == DATA_LAST) begin
                            bit_d   = 3'd0;
                            state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        samp_d = samp_q + 1'b1;
                    end
                end
                PARITY: begin
                    if (samp_q == SAMP_LAST) begin
                        samp_d  = {CNT_W{1'b0}};
                        perr_d  = (parity_of(shift_q) ^ rx_s) != 1'(PARITY_ODD);
                        state_d = STOP;
                    end else begin
                        samp_d = samp_q + 1'b1;
                    end
                end
                STOP: begin
                    if (samp_q == SAMP_LAST) begin
                        samp_d = {CNT_W{1'b0}};
                        ferr_d = ferr_q | ~rx_s;
                        if (bit_q == STOP_LAST) begin
                            bit_d   = 3'd0;
                            load_s  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        samp_d = samp_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output register: a load always wins over a same-cycle accept.
    always_comb begin
        data_out_d = data_out_q;
        valid_d    = valid_q;
        pe_d       = pe_q;
        fe_d       = fe_q;
        ovr_d      = 1'b0;
        busy_d     = (state_d != IDLE);
        if (load_s) begin
            data_out_d = shift_q;
            valid_d    = 1'b1;
            pe_d       = perr_q;
            fe_d       = ferr_d;
            ovr_d      = valid_q & ~rx_ready;
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            samp_q     <= {CNT_W{1'b0}};
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            data_out_q <= 8'h00;
            valid_q    <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            samp_q     <= samp_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
            ovr_q      <= ovr_d;
            busy_q     <= busy_d;
        end
    end

    assign data_out   = data_out_q;
    assign rx_valid   = valid_q;
    assign parity_err = pe_q;
    assign frame_err  = fe_q;
    assign overrun    = ovr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: default 8N1 instance plus a 7E1 instance,
// directed frames pushed to per-instance queues and checked by monitors.
module tb_uart_rx_os;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       rx0, rx7, ready0, ready7;
    logic [7:0] d0, d7;
    logic       v0, pe0, fe0, ov0, busy0;
    logic       v7, pe7, fe7, ov7, busy7;

    uart_rx_os dut (
        .clk(clk), .rst_n(rst_n), .baud_tick(1'b1), .rx(rx0),
        .data_out(d0), .rx_valid(v0), .rx_ready(ready0),
        .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .busy(busy0)
    );

    uart_rx_os #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0)) dut7 (
        .clk(clk), .rst_n(rst_n), .baud_tick(1'b1), .rx(rx7),
        .data_out(d7), .rx_valid(v7), .rx_ready(ready7),
        .parity_err(pe7), .frame_err(fe7), .overrun(ov7), .busy(busy7)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t q0[$];
    exp_t q7[$];
    exp_t e0, e7;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rise_cyc = 0;
    int lat = -1;
    int ovr_cnt = 0;
    logic busy_prev = 1'b0;
    logic v_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor for the default instance: compare on every accepted byte.
    always @(negedge clk) begin
        if (v0 && ready0) begin
            if (q0.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut0_unexpected_byte: got %0h expected none", d0);
            end else begin
                e0 = q0.pop_front();
                check("dut0_byte{d,pe,fe}", {22'd0, d0, pe0, fe0}, {22'd0, e0.d, e0.pe, e0.fe});
            end
        end
        if (ov0) ovr_cnt++;
        if (busy0 && !busy_prev) rise_cyc = cyc;
        if (v0 && !v_prev) lat = cyc - rise_cyc;
        busy_prev = busy0;
        v_prev    = v0;
    end

    // Monitor for the 7E1 instance.
    always @(negedge clk) begin
        if (v7 && ready7) begin
            if (q7.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut7_unexpected_byte: got %0h expected none", d7);
            end else begin
                e7 = q7.pop_front();
                check("dut7_byte{d,pe,fe}", {22'd0, d7, pe7, fe7}, {22'd0, e7.d, e7.pe, e7.fe});
            end
        end
    end

    task automatic drive(input bit which, input logic v);
        if (which) rx7 = v;
        else       rx0 = v;
    endtask

    // Sends a frame LSB first, 16 clk per bit; lim truncates it (no idle tail).
    task automatic send(input bit which, input logic [7:0] d, input int nb, input bit pe,
                        input bit pbit, input bit stop, input int lim);
        logic [11:0] f;
        int n;
        f = 12'hFFF;
        f[0] = 1'b0;
        for (int i = 0; i < nb; i++) f[1+i] = d[i];
        n = 1 + nb;
        if (pe) begin
            f[n] = pbit;
            n++;
        end
        f[n] = stop;
        n++;
        for (int i = 0; i < n && i < lim; i++) begin
            drive(which, f[i]);
            repeat (16) @(posedge clk);
            #1;
        end
        if (lim >= n) begin
            drive(which, 1'b1);
            repeat (32) @(posedge clk);
            #1;
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_data_out"}, {24'd0, d0}, 32'h0);
        check({name, "_flags{v,pe,fe,ov,busy}"}, {27'd0, v0, pe0, fe0, ov0, busy0}, 32'h0);
    endtask

    initial begin
        rst_n  = 1'b0;
        rx0    = 1'b1;
        rx7    = 1'b1;
        ready0 = 1'b1;
        ready7 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // 8N1 0xA5, load 152 ticks after detection
        q0.push_back('{8'hA5, 1'b0, 1'b0});
        send(1'b0, 8'hA5, 8, 1'b0, 1'b0, 1'b1, 99);
        check("latency_8n1", 32'(lat), 32'd152);

        // 7E1: 0x35 has four ones, so correct even parity bit is 0
        q7.push_back('{8'h35, 1'b0, 1'b0});
        send(1'b1, 8'h35, 7, 1'b1, 1'b0, 1'b1, 99);
        q7.push_back('{8'h35, 1'b1, 1'b0});
        send(1'b1, 8'h35, 7, 1'b1, 1'b1, 1'b1, 99);

        // Stop bit low, then a clean byte
        q0.push_back('{8'h3C, 1'b0, 1'b1});
        send(1'b0, 8'h3C, 8, 1'b0, 1'b0, 1'b0, 99);
        q0.push_back('{8'h96, 1'b0, 1'b0});
        send(1'b0, 8'h96, 8, 1'b0, 1'b0, 1'b1, 99);

        // 5-clk glitch on the idle line
        rx0 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("glitch_busy_high", {31'd0, busy0}, 32'd1);
        @(posedge clk);
        #1 rx0 = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("glitch_busy_low", {31'd0, busy0}, 32'd0);
        check("glitch_no_valid", {31'd0, v0}, 32'd0);

        // Overrun: 0x11 is overwritten by 0x22
        @(posedge clk);
        #1 ready0 = 1'b0;
        send(1'b0, 8'h11, 8, 1'b0, 1'b0, 1'b1, 99);
        q0.push_back('{8'h22, 1'b0, 1'b0});
        send(1'b0, 8'h22, 8, 1'b0, 1'b0, 1'b1, 99);
        @(negedge clk);
        check("overrun_data_out", {24'd0, d0}, 32'h22);
        check("overrun_valid_held", {31'd0, v0}, 32'd1);
        check("overrun_pulse_count", 32'(ovr_cnt), 32'd1);
        @(posedge clk);
        #1 ready0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("valid_cleared_after_accept", {31'd0, v0}, 32'd0);

        // Reset in the middle of 0x5A's data bits, then 0xC3
        @(posedge clk);
        #1;
        send(1'b0, 8'h5A, 8, 1'b0, 1'b0, 1'b1, 4);
        @(negedge clk);
        check("midframe_busy", {31'd0, busy0}, 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_outputs_zero("midframe_reset");
        rx0 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        q0.push_back('{8'hC3, 1'b0, 1'b0});
        send(1'b0, 8'hC3, 8, 1'b0, 1'b0, 1'b1, 99);

        repeat (40) @(posedge clk);
        @(negedge clk);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q7_drained", 32'(q7.size()), 32'd0);
        check("overrun_total", 32'(ovr_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised, oversampling UART receiver; successor to the simple shift-in receiver in the serial input path. Detects start bits by mid-bit sampling on an oversampled tick, shifts configurable-length frames LSB first, checks optional parity and stop bits, and presents each byte on a valid/ready handshake with per-byte error flags. It sits between the board RX pin and the CPU-side I/O register interface.

## Interface
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- OVERSAMPLE, 16, `baud_tick` pulses per bit; even, at least 4.
- PARITY_EN, 0, 1 means a parity bit follows the data.
- PARITY_ODD, 0, 1 selects odd parity, 0 selects even; ignored when PARITY_EN=0.
- STOP_BITS, 1, stop bits checked; 1 or 2.

- clk  in  1  single system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- baud_tick  in  1  one-cycle strobe at OVERSAMPLE × baud rate; tie high for one tick per clk.
- rx  in  1  raw serial line, asynchronous, idle high.
- data_out  out  8  received byte, LSB-aligned; bits above DATA_BITS are 0.
- rx_valid  out  1  data_out and flags are valid.
- rx_ready  in  1  consumer accepts when rx_valid && rx_ready.
- parity_err  out  1  parity mismatch on the current byte; 0 when PARITY_EN=0.
- frame_err  out  1  a stop bit sampled low on the current byte.
- overrun  out  1  one-cycle pulse when a frame completes while rx_valid is still high.
- busy  out  1  FSM not in IDLE.

## Operation
- rx passes through a 2-flop synchronizer, reset to 1. All decisions use the synchronized value.
- The FSM has states IDLE, START, DATA, PARITY and STOP. A sample counter counts baud_tick from 0 to OVERSAMPLE-1. A bit counter tracks data and stop bits.
- IDLE: on a tick with sync rx=0, clear the sample counter and go to START.
- START: at sample OVERSAMPLE/2-1, if rx=1 the start bit was a glitch; return to IDLE with nothing emitted. If rx=0, zero the sample counter. That point is now mid-bit, and every later bit is sampled when the counter wraps at OVERSAMPLE-1.
- DATA: shift LSB first into the shift register. After DATA_BITS samples, go to PARITY if PARITY_EN, otherwise to STOP.
- PARITY: sample one bit. Error when XOR(data bits, parity bit) ≠ PARITY_ODD.
- STOP: sample STOP_BITS bits; any 0 sets frame error. At the final stop sample, load the output register, return to IDLE immediately, and re-arm start detection mid-stop bit.
- Output register: on load, set rx_valid=1 and load data_out, parity_err and frame_err. Cleared by the handshake.
- Overrun: if a load occurs while rx_valid=1 and rx_ready=0:
  - the new frame overwrites the register;
  - rx_valid stays 1;
  - overrun pulses.
- Load and accept in the same cycle: the new byte wins, rx_valid stays 1, no overrun.
- baud_tick low: the FSM and counters hold. The handshake still operates.

## Timing
- Reset values:
  - data_out=0;
  - rx_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0;
  - FSM in IDLE, synchronizer stages 1.
- Reset mid-frame: abort the frame immediately; no partial byte is emitted.
- Start-edge to FSM latency: 2 clk for synchronizer, then first tick.
- Frame length, in ticks from start detect to load: OVERSAMPLE/2 + OVERSAMPLE·(DATA_BITS + PARITY_EN + STOP_BITS).
- rx_valid rises on the clk after the final stop-sample tick. It falls on the clk after rx_ready is sampled high with rx_valid.
- overrun is high for exactly one clk, aligned with the load.

## Structure
- Shared package uart_pkg:
  - state enum {IDLE, START, DATA, PARITY, STOP};
  - constants for the legal DATA_BITS and STOP_BITS ranges.
- Sub-module uart_sync2: 2-flop synchronizer with reset value parameter. Reused by future UART/GPIO inputs.
- Elaboration-time checks reject illegal parameter values.

## Test plan
- Default parameters, baud_tick=1, send 0xA5 (8N1), rx_ready=1 → rx_valid one clk, data_out=0xA5, errors 0, load at tick 8+16·9=152 after detection.
- DATA_BITS=7, PARITY_EN=1, PARITY_ODD=0, send 0x35 with correct parity, then with flipped parity → 0x35 with parity_err=0, then 0x35 with parity_err=1.
- Stop bit driven 0 on byte 0x3C → data_out=0x3C, frame_err=1; next clean byte → frame_err=0.
- Low pulse of 5 ticks on idle line → returns to IDLE, rx_valid never asserts, busy drops.
- rx_ready=0, send 0x11 then 0x22 → overrun pulses once at second load, data_out=0x22. Raising rx_ready clears rx_valid next clk.
- Assert rst_n=0 mid-DATA of 0x5A, release, send 0xC3 → only 0xC3 emitted. All outputs 0 during reset.
